// File: rtl/vga_sync_gen.sv
// VGA timing generator: divide-by-CLK_DIV pixel enable, row/column counters,
// and sync/video flags delayed by PIPE_DLY pixel ticks to match pixel lookup.
module vga_sync_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   CLK_DIV  = 4,
    parameter logic SYNC_POL = 1'b0,
    parameter int   PIPE_DLY = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    output logic       pix_ce,
    output logic [9:0] pixel_row,
    output logic [9:0] pixel_column,
    output logic       horiz_sync,
    output logic       vert_sync,
    output logic       video_on,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // Decode bounds use 11 bits so a sync end of exactly 1024 still fits.
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam int NS = (PIPE_DLY > 1) ? PIPE_DLY - 1 : 1;

    logic [3:0] r_div;
    logic       r_pix_ce;
    logic [9:0] r_row;
    logic [9:0] r_col;
    logic       r_hs;
    logic       r_vs;
    logic       r_von;
    logic       r_line_start;
    logic       r_frame_start;
    logic [2:0] r_dly [NS];

    logic       w_col_wrap;
    logic       w_row_wrap;
    logic [9:0] w_col_nxt;
    logic [9:0] w_row_nxt;
    logic [2:0] w_raw_cur;
    logic [2:0] w_raw_nxt;
    logic [2:0] w_tap;

    // Returns {hs, vs, von} for one counter position, all active-high.
    function automatic logic [2:0] decode(input logic [9:0] row, input logic [9:0] col);
        logic [10:0] r;
        logic [10:0] c;
        r = {1'b0, row};
        c = {1'b0, col};
        return {(c >= HS_START) && (c < HS_END),
                (r >= VS_START) && (r < VS_END),
                (c < H_VIS) && (r < V_VIS)};
    endfunction

    assign w_col_wrap = (r_col == H_LAST);
    assign w_row_wrap = (r_row == V_LAST);
    assign w_col_nxt  = w_col_wrap ? 10'd0 : r_col + 10'd1;
    assign w_row_nxt  = w_col_wrap ? (w_row_wrap ? 10'd0 : r_row + 10'd1) : r_row;
    assign w_raw_cur  = decode(r_row, r_col);
    assign w_raw_nxt  = decode(w_row_nxt, w_col_nxt);

    // Output flops sit on the last tick of the delay; with no delay they track
    // the counters' next value so they change on the same clk as the counters.
    always_comb begin
        w_tap = w_raw_nxt;
        if (PIPE_DLY == 1) begin
            w_tap = w_raw_cur;
        end else if (PIPE_DLY > 1) begin
            w_tap = r_dly[NS-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div         <= '0;
            r_pix_ce      <= 1'b0;
            r_row         <= '0;
            r_col         <= '0;
            r_hs          <= ~SYNC_POL;
            r_vs          <= ~SYNC_POL;
            r_von         <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            for (int i = 0; i < NS; i++) begin
                r_dly[i] <= '0;
            end
        end else if (!enable) begin
            r_div         <= '0;
            r_pix_ce      <= 1'b0;
            r_row         <= '0;
            r_col         <= '0;
            r_hs          <= ~SYNC_POL;
            r_vs          <= ~SYNC_POL;
            r_von         <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            for (int i = 0; i < NS; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            r_div         <= (r_div == DIV_LAST) ? 4'd0 : r_div + 4'd1;
            r_pix_ce      <= (r_div == DIV_LAST);
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (r_pix_ce) begin
                r_col         <= w_col_nxt;
                r_row         <= w_row_nxt;
                r_line_start  <= w_col_wrap;
                r_frame_start <= w_col_wrap && w_row_wrap;
                r_dly[0]      <= w_raw_cur;
                for (int i = 1; i < NS; i++) begin
                    r_dly[i] <= r_dly[i-1];
                end
                r_hs  <= w_tap[2] ? SYNC_POL : ~SYNC_POL;
                r_vs  <= w_tap[1] ? SYNC_POL : ~SYNC_POL;
                r_von <= w_tap[0];
            end
        end
    end

    assign pix_ce       = r_pix_ce;
    assign pixel_row    = r_row;
    assign pixel_column = r_col;
    assign horiz_sync   = r_hs;
    assign vert_sync    = r_vs;
    assign video_on     = r_von;
    assign line_start   = r_line_start;
    assign frame_start  = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two small-geometry instances and one default
// instance, all checked every cycle against a closed-form timing model.
module tb_vga_sync_gen;

    localparam int SH_A = 16, SH_F = 2, SH_S = 4, SH_B = 3;
    localparam int SV_A = 8,  SV_F = 2, SV_S = 2, SV_B = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic enable  = 1'b0;

    logic       d_ce  [3];
    logic [9:0] d_row [3];
    logic [9:0] d_col [3];
    logic       d_hs  [3];
    logic       d_vs  [3];
    logic       d_von [3];
    logic       d_ls  [3];
    logic       d_fs  [3];

    int total = 0;
    int bad   = 0;
    int k     = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
        .CLK_DIV(3), .SYNC_POL(1'b0), .PIPE_DLY(2)
    ) u0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pix_ce(d_ce[0]),
        .pixel_row(d_row[0]), .pixel_column(d_col[0]), .horiz_sync(d_hs[0]),
        .vert_sync(d_vs[0]), .video_on(d_von[0]), .line_start(d_ls[0]),
        .frame_start(d_fs[0])
    );

    vga_sync_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
        .CLK_DIV(1), .SYNC_POL(1'b1), .PIPE_DLY(0)
    ) u1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pix_ce(d_ce[1]),
        .pixel_row(d_row[1]), .pixel_column(d_col[1]), .horiz_sync(d_hs[1]),
        .vert_sync(d_vs[1]), .video_on(d_von[1]), .line_start(d_ls[1]),
        .frame_start(d_fs[1])
    );

    vga_sync_gen u2 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pix_ce(d_ce[2]),
        .pixel_row(d_row[2]), .pixel_column(d_col[2]), .horiz_sync(d_hs[2]),
        .vert_sync(d_vs[2]), .video_on(d_von[2]), .line_start(d_ls[2]),
        .frame_start(d_fs[2])
    );

    // k = clk edges seen since timing last restarted from the origin.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)     k <= 0;
        else if (!enable) k <= 0;
        else              k <= k + 1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Expected {pix_ce, row, col, hs, vs, von, line_start, frame_start}.
    function automatic logic [25:0] model(input int kk, input int inst);
        int ha, hf, hw, hb, va, vf, vw, vb, dv, dl;
        int ht, vt, t, col, row, pt, pc, pr;
        logic pol, ce, upd, ls, fs, hs, vs, von;
        if (inst == 2) begin
            ha = 640; hf = 16; hw = 96; hb = 48; va = 480; vf = 10; vw = 2; vb = 33;
            dv = 4; dl = 2; pol = 1'b0;
        end else begin
            ha = SH_A; hf = SH_F; hw = SH_S; hb = SH_B;
            va = SV_A; vf = SV_F; vw = SV_S; vb = SV_B;
            dv = (inst == 0) ? 3 : 1;
            dl = (inst == 0) ? 2 : 0;
            pol = (inst == 0) ? 1'b0 : 1'b1;
        end
        ht = ha + hf + hw + hb;
        vt = va + vf + vw + vb;
        t = (kk == 0) ? 0 : (kk - 1) / dv;
        ce = (kk >= 1) && (kk % dv == 0);
        upd = (kk >= 2) && ((kk - 1) % dv == 0);
        col = t % ht;
        row = (t / ht) % vt;
        ls = upd && (col == 0);
        fs = ls && (row == 0);
        hs = 1'b0; vs = 1'b0; von = 1'b0;
        if (t >= 1 && t >= dl) begin
            pt = t - dl;
            pc = pt % ht;
            pr = (pt / ht) % vt;
            hs = (pc >= ha + hf) && (pc < ha + hf + hw);
            vs = (pr >= va + vf) && (pr < va + vf + vw);
            von = (pc < ha) && (pr < va);
        end
        return {ce, 10'(row), 10'(col), hs ? pol : ~pol, vs ? pol : ~pol, von, ls, fs};
    endfunction

    function automatic logic [25:0] dut_vec(input int i);
        return {d_ce[i], d_row[i], d_col[i], d_hs[i], d_vs[i], d_von[i], d_ls[i], d_fs[i]};
    endfunction

    task automatic check_vec(input string name, input logic [25:0] got, input logic [25:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t: wait bound expired", name, $time);
    endtask

    int last_fs0 = -1, last_fs1 = -1, last_ls2 = -1;

    always @(negedge clk) begin
        check_vec("u0_cycle", dut_vec(0), model(k, 0));
        check_vec("u1_cycle", dut_vec(1), model(k, 1));
        check_vec("u2_cycle", dut_vec(2), model(k, 2));
        if (k == 0) begin
            last_fs0 = -1; last_fs1 = -1; last_ls2 = -1;
        end
        if (d_fs[0]) begin
            if (last_fs0 >= 0) check_int("u0_frame_period", cyc - last_fs0, 1125);
            last_fs0 = cyc;
        end
        if (d_fs[1]) begin
            if (last_fs1 >= 0) check_int("u1_frame_period", cyc - last_fs1, 375);
            last_fs1 = cyc;
        end
        if (d_ls[2]) begin
            if (last_ls2 >= 0) check_int("u2_line_period", cyc - last_ls2, 3200);
            last_ls2 = cyc;
        end
    end

    initial begin
        int first [3];
        logic [25:0] prev;
        bit found;

        // Hand-computed points that pin the model itself.
        check_vec("model_first_tick", model(4, 2), {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        check_vec("model_hs_onset", model(2633, 2), {1'b0, 10'd0, 10'd658, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        check_vec("model_wrap", model(1126, 0), {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
        check_vec("model_div1", model(1, 1), {1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        enable = 1'b1;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;

        first = '{-1, -1, -1};
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) if (first[i] < 0 && d_ce[i]) first[i] = n;
        end
        check_int("first_ce_u0", first[0], 3);
        check_int("first_ce_u1", first[1], 1);
        check_int("first_ce_u2", first[2], 4);

        found = 0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (!d_hs[2]) begin found = 1; break; end
        end
        if (found) check_int("u2_hs_fall_col", int'(d_col[2]), 658);
        else timeout("u2_hs_fall");
        found = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (d_hs[2]) begin found = 1; break; end
        end
        if (found) check_int("u2_hs_rise_col", int'(d_col[2]), 754);
        else timeout("u2_hs_rise");

        @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_vec("async_rst_u0", dut_vec(0), {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        check_vec("async_rst_u1", dut_vec(1), {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;

        found = 0;
        prev = '0;
        for (int n = 0; n < 1500; n++) begin
            prev = dut_vec(0);
            @(negedge clk);
            if (d_fs[0]) begin found = 1; break; end
        end
        if (found) begin
            check_int("wrap_prev_row", int'(prev[24:15]), 14);
            check_int("wrap_prev_col", int'(prev[14:5]), 24);
            check_vec("wrap_now", dut_vec(0) & 26'h3ff_ffe3, {1'b0, 10'd0, 10'd0, 5'b00011} & 26'h3ff_ffe3);
        end else timeout("wrap_frame_start");

        found = 0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if (d_row[0] == 10'd5 && d_col[0] == 10'd10) begin found = 1; break; end
        end
        if (!found) timeout("u0_reach_5_10");
        #1 enable = 1'b0;
        @(negedge clk);
        check_vec("en_drop_u0", dut_vec(0), {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        check_vec("en_drop_u1", dut_vec(1), {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        #1 enable = 1'b1;

        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(50, 2500)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                #2 reset_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                #1 reset_n = 1'b1;
            end else begin
                #1 enable = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                #1 enable = 1'b1;
            end
        end
        repeat (2600) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
